// File: rtl/ita_step_sequencer_if.sv
// Tile-command channel between the step sequencer and the datapath controller.
// The sequencer drives a command and holds it until the controller accepts it with cmd_ready.
interface ita_step_sequencer_if #(
  parameter int H            = 1,
  parameter int TileCntWidth = 32
);
  localparam int HW = (H > 1) ? $clog2(H) : 1;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [2:0]              cmd_step;
  logic [HW-1:0]           cmd_head;
  logic [TileCntWidth-1:0] cmd_tile;
  logic                    cmd_last;

  modport master (
    output cmd_valid, cmd_step, cmd_head, cmd_tile, cmd_last,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_step, cmd_head, cmd_tile, cmd_last,
    output cmd_ready
  );
endinterface

// File: rtl/ita_step_sequencer.sv
// Step/tile sequencer for the ITA controller. It latches a run configuration on start,
// then walks heads and, within each head, the steps Q, K, V, QK, AV, OW. It issues one
// tile command per handshake and skips inactive steps without spending cycles on them.
module ita_step_sequencer #(
  parameter int H            = 1,
  parameter int TileCntWidth = 32,
  parameter int NumSteps     = 6,
  localparam int NHW         = $clog2(H + 1),
  localparam int HW          = (H > 1) ? $clog2(H) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [NHW-1:0]          n_heads_i,
  input  logic [TileCntWidth-1:0] lin_tiles_i,
  input  logic [TileCntWidth-1:0] attn_tiles_i,
  input  logic [NumSteps-1:0]     step_en_i,
  ita_step_sequencer_if.master    cmd,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [2:0] STEP_QK   = 3'd3;
  localparam logic [2:0] STEP_AV   = 3'd4;
  localparam logic [2:0] STEP_IDLE = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [NHW-1:0]          nh_q, nh_d, nh_clamped;
  logic [TileCntWidth-1:0] lin_q, lin_d, attn_q, attn_d;
  logic [NumSteps-1:0]     en_q, en_d, act_q, act_in;
  logic [HW-1:0]           head_q, head_d;
  logic [2:0]              step_q, step_d;
  logic [TileCntWidth-1:0] tile_q, tile_d, cnt_cur;
  logic [3:0]              first_in, first_q, next_q;
  logic                    start_ok, tile_last, head_last, final_cmd, valid;

  // A step is active when enabled and its class has at least one tile (OW,AV,QK,V,K,Q).
  function automatic logic [NumSteps-1:0] active_mask(input logic [NumSteps-1:0] en,
                                                      input logic [TileCntWidth-1:0] lin,
                                                      input logic [TileCntWidth-1:0] attn);
    logic lnz, anz;
    lnz = |lin;
    anz = |attn;
    return en & {lnz, anz, anz, lnz, lnz, lnz};
  endfunction

  // Lowest active step at or after 'from'; bit 3 flags that one was found.
  function automatic logic [3:0] find_from(input logic [NumSteps-1:0] act,
                                           input logic [2:0] from);
    logic [3:0] r;
    r = 4'b0;
    for (int s = NumSteps - 1; s >= 0; s--) begin
      if (act[s] && (s >= int'(from))) r = {1'b1, 3'(s)};
    end
    return r;
  endfunction

  assign nh_clamped = (n_heads_i > NHW'(H)) ? NHW'(H) : n_heads_i;
  assign act_in     = active_mask(step_en_i, lin_tiles_i, attn_tiles_i);
  assign first_in   = find_from(act_in, 3'd0);
  assign act_q      = active_mask(en_q, lin_q, attn_q);
  assign first_q    = find_from(act_q, 3'd0);
  assign next_q     = find_from(act_q, 3'(step_q + 3'd1));

  assign cnt_cur    = (step_q == STEP_QK || step_q == STEP_AV) ? attn_q : lin_q;
  assign tile_last  = (tile_q == cnt_cur - TileCntWidth'(1));
  assign head_last  = (int'(head_q) + 1 == int'(nh_q));
  assign final_cmd  = tile_last && !next_q[3] && head_last;

  assign valid      = (state_q == S_ISSUE);
  assign start_ok   = (state_q == S_IDLE) && start_i && !abort_i && !rst_i;

  assign cmd.cmd_valid = valid;
  assign cmd.cmd_step  = valid ? step_q : STEP_IDLE;
  assign cmd.cmd_head  = valid ? head_q : '0;
  assign cmd.cmd_tile  = valid ? tile_q : '0;
  assign cmd.cmd_last  = valid && final_cmd;
  assign busy_o        = (state_q != S_IDLE) || start_ok;
  assign done_o        = (state_q == S_DONE) && !abort_i;

  // State, latched configuration and walk position registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      nh_q    <= '0;
      lin_q   <= '0;
      attn_q  <= '0;
      en_q    <= '0;
      head_q  <= '0;
      step_q  <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      nh_q    <= nh_d;
      lin_q   <= lin_d;
      attn_q  <= attn_d;
      en_q    <= en_d;
      head_q  <= head_d;
      step_q  <= step_d;
      tile_q  <= tile_d;
    end
  end

  // Next-state logic: start/latch, tile/step/head advance on handshake, abort, completion.
  always_comb begin
    state_d = state_q;
    nh_d    = nh_q;
    lin_d   = lin_q;
    attn_d  = attn_q;
    en_d    = en_q;
    head_d  = head_q;
    step_d  = step_q;
    tile_d  = tile_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          nh_d   = nh_clamped;
          lin_d  = lin_tiles_i;
          attn_d = attn_tiles_i;
          en_d   = step_en_i;
          head_d = '0;
          tile_d = '0;
          if (first_in[3] && (nh_clamped != '0)) begin
            step_d  = first_in[2:0];
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cmd.cmd_ready) begin
          if (!tile_last) begin
            tile_d = tile_q + TileCntWidth'(1);
          end else begin
            tile_d = '0;
            if (next_q[3]) begin
              step_d = next_q[2:0];
            end else if (!head_last) begin
              head_d = head_q + HW'(1);
              step_d = first_q[2:0];
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
